imm_gen_pipe: RTL and testbench

Pipelined immediate generator for the decode stage: accepts one 32-bit RISC-V instruction word plus a format select per beat, produces the sign-extended immediate at a parametrised data width, and carries a sideband tag. It is the registered, flow-controlled successor to the combinational sign extender, with valid/ready handshakes on both sides and a skid buffer so decode backpressure never drops a beat. It sits between the fetch/decode register and the operand-select logic.

---
 rtl/imm_pkg.sv | 19 +
 rtl/imm_decode.sv | 40 ++++
 rtl/imm_gen_pipe.sv | 85 ++++++++
 tb/tb_imm_gen_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the pipelined immediate generator.
// Format select codes, plus the XLEN legality check used at elaboration.
package imm_pkg;

  localparam logic [2:0] SEL_I    = 3'b000;
  localparam logic [2:0] SEL_S    = 3'b001;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_U    = 3'b011;
  localparam logic [2:0] SEL_J    = 3'b100;
  localparam logic [2:0] SEL_ZIMM = 3'b101;

  localparam int XLEN_NARROW = 32;
  localparam int XLEN_WIDE   = 64;

  function automatic bit imm_xlen_ok(input int xlen);
    return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: (instr, sel) -> (imm, err) at XLEN.
// Optional build macro IMM_GEN_ZIMM_EN enables the CSR zimm format (sel 101);
// without it, sel 101 is reserved like 110/111.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      sel_ext,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic signed [31:0] imm32;

  // Build a 32-bit sign-extended value, then widen to XLEN.
  always_comb begin
    imm32 = '0;
    imm   = '0;
    err   = 1'b0;
    unique case (sel_ext)
      SEL_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      SEL_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_U: imm32 = {instr[31:12], 12'b0};
      SEL_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: err = 1'b1;
    endcase
    imm = XLEN'(imm32);
`ifdef IMM_GEN_ZIMM_EN
    // zimm is an unsigned register-index field, so it is zero-extended
    if (sel_ext == SEL_ZIMM) begin
      imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      err = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, flow-controlled immediate generator with a one-entry skid buffer.
// Build macro IMM_GEN_ZIMM_EN (see imm_decode) enables the CSR zimm format.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_full,
  input  logic [2:0]       sel_ext,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (!imm_xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;
  logic             accept;
  logic             unused_opcode;

  // opcode bits carry no immediate content
  assign unused_opcode = ^instr_full[6:0];

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr_full[31:7]),
    .sel_ext (sel_ext),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  // Skid register empty means there is always a slot for one more beat.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  // Output register refills from skid first (FIFO order), else from the input;
  // a stalled accept parks in the skid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      imm_ext    <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        imm_ext    <= skid_imm;
        out_tag    <= skid_tag;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        imm_ext   <= dec_imm;
        out_tag   <= in_tag;
        out_err   <= dec_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_tag   <= in_tag;
      skid_err   <= dec_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe; XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      instr_full;
  logic [2:0]       sel_ext;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready_32, out_valid_32, out_err_32;
  logic [31:0]      imm_32;
  logic [TAG_W-1:0] tag_32;
  logic             in_ready_64, out_valid_64, out_err_64;
  logic [63:0]      imm_64;
  logic [TAG_W-1:0] tag_64;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
    .instr_full(instr_full), .sel_ext(sel_ext), .in_tag(in_tag),
    .out_valid(out_valid_32), .out_ready(out_ready), .imm_ext(imm_32),
    .out_tag(tag_32), .out_err(out_err_32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
    .instr_full(instr_full), .sel_ext(sel_ext), .in_tag(in_tag),
    .out_valid(out_valid_64), .out_ready(out_ready), .imm_ext(imm_64),
    .out_tag(tag_64), .out_err(out_err_64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] sel, input logic [TAG_W-1:0] tg);
    in_valid   = 1'b1;
    instr_full = ins;
    sel_ext    = sel;
    in_tag     = tg;
  endtask

  // Offer one beat with out_ready=1; it must be on the outputs right after the edge.
  task automatic beat(input string nm, input logic [31:0] ins, input logic [2:0] sel,
                      input logic [TAG_W-1:0] tg, input logic [63:0] exp64, input logic exp_err);
    drive(ins, sel, tg);
    chk({nm, " in_ready"}, 64'(in_ready_32 & in_ready_64), 64'd1);
    step();
    chk({nm, " valid32"}, 64'(out_valid_32), 64'd1);
    chk({nm, " valid64"}, 64'(out_valid_64), 64'd1);
    chk({nm, " imm32"},   64'(imm_32), {32'd0, exp64[31:0]});
    chk({nm, " imm64"},   imm_64, exp64);
    chk({nm, " err32"},   64'(out_err_32), 64'(exp_err));
    chk({nm, " err64"},   64'(out_err_64), 64'(exp_err));
    chk({nm, " tag"},     64'(tag_32), 64'(tg));
    chk({nm, " tag64"},   64'(tag_64), 64'(tg));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr_full = '0; sel_ext = '0; in_tag = '0; out_ready = 1'b1;
    step(); step();
    chk("rst valid",  64'(out_valid_32 | out_valid_64), 64'd0);
    chk("rst imm64",  imm_64, 64'd0);
    chk("rst imm32",  64'(imm_32), 64'd0);
    chk("rst tag",    64'(tag_32 | tag_64), 64'd0);
    chk("rst err",    64'(out_err_32 | out_err_64), 64'd0);
    rst = 1'b0;
    step();
    chk("post-rst in_ready", 64'(in_ready_32 & in_ready_64), 64'd1);
    chk("post-rst valid",    64'(out_valid_32 | out_valid_64), 64'd0);

    // single beats, then back-to-back with tags 1,2,3
    beat("I neg",  32'hffb00193, SEL_I, 5'd7,  64'hffff_ffff_ffff_fffb, 1'b0);
    in_valid = 1'b0; step();
    chk("drain idle", 64'(out_valid_32), 64'd0);
    beat("U pos",  32'h123450b7, SEL_U, 5'd8,  64'h0000_0000_1234_5000, 1'b0);
    beat("U neg",  32'hfffff037, SEL_U, 5'd9,  64'hffff_ffff_ffff_f000, 1'b0);
    beat("B neg",  32'hfe000ee3, SEL_B, 5'd1,  64'hffff_ffff_ffff_fffc, 1'b0);
    beat("S neg",  32'hfe112e23, SEL_S, 5'd2,  64'hffff_ffff_ffff_fffc, 1'b0);
    beat("J pos",  32'h0080006f, SEL_J, 5'd3,  64'h0000_0000_0000_0008, 1'b0);
    beat("J neg",  32'hff9ff06f, SEL_J, 5'd4,  64'hffff_ffff_ffff_fff8, 1'b0);
    beat("I pos",  32'h00500093, SEL_I, 5'd5,  64'h0000_0000_0000_0005, 1'b0);
    beat("ill110", 32'hffb00193, 3'b110, 5'd6, 64'd0, 1'b1);
    beat("ill111", 32'hffffffff, 3'b111, 5'd10, 64'd0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
    beat("zimm",   32'h000fd073, SEL_ZIMM, 5'd11, 64'h0000_0000_0000_001f, 1'b0);
`else
    beat("zimm",   32'h000fd073, SEL_ZIMM, 5'd11, 64'd0, 1'b1);
`endif
    in_valid = 1'b0; step();
    chk("idle valid", 64'(out_valid_32 | out_valid_64), 64'd0);

    // backpressure: three beats offered with out_ready=0
    out_ready = 1'b0;
    drive(32'h00500093, SEL_I, 5'd12);
    step();
    chk("bp b1 valid",   64'(out_valid_32), 64'd1);
    chk("bp b1 ready",   64'(in_ready_32), 64'd1);
    drive(32'hfe000ee3, SEL_B, 5'd13);
    step();
    chk("bp skid ready", 64'(in_ready_32 | in_ready_64), 64'd0);
    chk("bp hold tag",   64'(tag_32), 64'd12);
    drive(32'h0080006f, SEL_J, 5'd14);
    step();
    chk("bp still full", 64'(in_ready_32), 64'd0);
    chk("bp hold tag2",  64'(tag_64), 64'd12);
    chk("bp hold imm",   imm_64, 64'd5);
    out_ready = 1'b1;
    step();
    chk("bp b2 tag",     64'(tag_32), 64'd13);
    chk("bp b2 imm",     imm_64, 64'hffff_ffff_ffff_fffc);
    chk("bp ready back", 64'(in_ready_32 & in_ready_64), 64'd1);
    step();
    chk("bp b3 tag",     64'(tag_32), 64'd14);
    chk("bp b3 imm",     64'(imm_32), 64'd8);
    chk("bp b3 valid",   64'(out_valid_32), 64'd1);
    in_valid = 1'b0;
    step();
    chk("bp empty",      64'(out_valid_32 | out_valid_64), 64'd0);

    // reset with both registers full
    out_ready = 1'b0;
    drive(32'hffb00193, SEL_I, 5'd20); step();
    drive(32'h123450b7, SEL_U, 5'd21); step();
    in_valid = 1'b0;
    chk("full ready", 64'(in_ready_32), 64'd0);
    chk("full valid", 64'(out_valid_32), 64'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst mid valid", 64'(out_valid_32 | out_valid_64), 64'd0);
    chk("rst mid ready", 64'(in_ready_32 & in_ready_64), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no stale", 64'(out_valid_32 | out_valid_64), 64'd0);
    end
    beat("post rst", 32'h00500093, SEL_I, 5'd22, 64'd5, 1'b0);
    in_valid = 1'b0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
